// File: rtl/nibble_serial_adder_if.sv
// Request/response bus of nibble_serial_adder.
// master: the requester driving operands; slave: the serial adder itself.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
) ();
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;

   modport master (
      output start, op_a, op_b, cin,
      input  busy, done, result, cout
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output busy, done, result, cout
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide unsigned add reusing one external 4-bit adder,
// one nibble per cycle, LSB nibble first, carry chained through a register.
// Optional macro NIBBLE_SERIAL_ADD_OVF_EN adds the signed overflow output ovf.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result/cout hold the last sum
// RUN   | one nibble through the external adder per edge
// DONE  | done pulse for one cycle, result/cout final
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   nibble_serial_adder_if.slave    req,
   output logic [3:0]              add_a,
   output logic [3:0]              add_b,
   output logic                    add_cin,
   input  logic [3:0]              add_sum,
   input  logic                    add_cout
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
   ,
   output logic                    ovf
`endif
);
   localparam int       W    = 4 * NIBBLES;
   localparam logic [2:0] LAST = 3'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] a_sh_q, a_sh_d;
   logic [W-1:0] b_sh_q, b_sh_d;
   logic         carry_q, carry_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [W-1:0] result_q, result_d;
   logic         cout_q, cout_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [W+3:0] res_shift;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
   logic         ovf_q, ovf_d;
`endif

   // Adder drive is live only in RUN so the shared adder sees zeros otherwise.
   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (state_q == S_RUN) begin
         add_a   = a_sh_q[3:0];
         add_b   = b_sh_q[3:0];
         add_cin = carry_q;
      end
   end

   // Next-state and datapath update for all registers.
   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      cout_d    = cout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      res_shift = {add_sum, result_q};
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
      ovf_d     = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (req.start) begin
               a_sh_d  = req.op_a;
               b_sh_d  = req.op_b;
               carry_d = req.cin;
               cnt_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 4;
            b_sh_d   = b_sh_q >> 4;
            carry_d  = add_cout;
            result_d = res_shift[W+3:4];
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
               cout_d  = add_cout;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
               ovf_d   = (a_sh_q[3] == b_sh_q[3]) && (add_sum[3] != a_sh_q[3]);
`endif
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= 3'd0;
         result_q <= '0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign req.busy   = busy_q;
   assign req.done   = done_q;
   assign req.result = result_q;
   assign req.cout   = cout_q;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
   assign ovf        = ovf_q;
`endif

endmodule
